// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter in front of mem_control.
package mem_arbiter_pkg;

  localparam logic [1:0] MEM_ACCESS_BYTE = 2'b00;
  localparam logic [1:0] MEM_ACCESS_HALF = 2'b01;
  localparam logic [1:0] MEM_ACCESS_WORD = 2'b10;

  localparam logic MEM_OWNER_FETCH = 1'b0;
  localparam logic MEM_OWNER_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        owner;
    logic        we;
    logic [1:0]  acc;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
  } mem_cmd_t;

  function automatic logic misaligned(input logic [1:0] acc, input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    if (acc == MEM_ACCESS_HALF) bad = lsb[0];
    else if (acc == MEM_ACCESS_WORD) bad = (lsb != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker; on a tie the port that did not win last time gets the grant.
module mem_arb_rr
  import mem_arbiter_pkg::*;
(
  input  logic req_fetch,
  input  logic req_data,
  input  logic last,
  input  logic en,
  output logic gnt_fetch,
  output logic gnt_data
);

  always_comb begin
    gnt_fetch = 1'b0;
    gnt_data  = 1'b0;
    if (en) begin
      if (req_fetch && req_data) begin
        gnt_data  = (last == MEM_OWNER_FETCH);
        gnt_fetch = (last == MEM_OWNER_DATA);
      end else begin
        gnt_fetch = req_fetch;
        gnt_data  = req_data;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares mem_control between instruction fetch and load/store, one checked access per 2-cycle slot
// (grant, issue, hold/response).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [31:0] MAP_ZERO = 32'h0,
  parameter int unsigned ROWS     = 512
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [1:0]  d_acc_i,
  input  logic        d_sext_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic        d_wack_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        mem_sext_o,
  output logic        mem_r_en_o,
  output logic [1:0]  mem_acc_r_o,
  output logic [31:0] mem_addr_r_o,
  input  logic [31:0] mem_data_r_i,
  output logic        mem_wr_en_o,
  output logic [1:0]  mem_acc_w_o,
  output logic [31:0] mem_addr_w_o,
  output logic [31:0] mem_data_w_o,
  input  logic        mem_wr_ready_i
);

  localparam logic [32:0] SPAN = 33'(ROWS) << 2;

  arb_state_t state, state_next;
  mem_cmd_t   cmd, cmd_load;
  logic       mem_up;
  logic       last;
  logic       gnt_fetch, gnt_data, grant, grant_en;
  logic       cmd_active, cmd_read, cmd_write, if_resp, d_resp;

  // Offset from MAP_ZERO in 34 bits: the top bit catches addresses below the base,
  // and the 33-bit compare keeps MAP_ZERO+4*ROWS from wrapping.
  function automatic logic out_of_range(input logic [31:0] a);
    logic [33:0] off;
    off = {2'b00, a} - {2'b00, MAP_ZERO};
    return off[33] || (off[32:0] >= SPAN);
  endfunction

  assign grant_en = mem_up && ((state == ST_IDLE) || (state == ST_HOLD));
  assign grant    = gnt_fetch || gnt_data;
  assign if_gnt_o = gnt_fetch;
  assign d_gnt_o  = gnt_data;

  mem_arb_rr u_rr (
    .req_fetch (if_req_i),
    .req_data  (d_req_i),
    .last      (last),
    .en        (grant_en),
    .gnt_fetch (gnt_fetch),
    .gnt_data  (gnt_data)
  );

  always_comb begin
    cmd_load       = '0;
    cmd_load.owner = MEM_OWNER_FETCH;
    cmd_load.acc   = MEM_ACCESS_WORD;
    cmd_load.addr  = if_addr_i;
    cmd_load.err   = misaligned(MEM_ACCESS_WORD, if_addr_i[1:0]) || out_of_range(if_addr_i);
    if (gnt_data) begin
      cmd_load.owner = MEM_OWNER_DATA;
      cmd_load.we    = d_we_i;
      cmd_load.acc   = d_acc_i;
      cmd_load.sext  = d_sext_i;
      cmd_load.addr  = d_addr_i;
      cmd_load.wdata = d_wdata_i;
      cmd_load.err   = misaligned(d_acc_i, d_addr_i[1:0]) || out_of_range(d_addr_i);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (grant) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_HOLD;
      ST_HOLD:  state_next = grant ? ST_ISSUE : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // mem_up stays low until mem_control first reports ready, so nothing is granted into its reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state  <= ST_IDLE;
      last   <= MEM_OWNER_FETCH;
      mem_up <= 1'b0;
      cmd    <= '0;
    end else begin
      state <= state_next;
      if (mem_wr_ready_i) mem_up <= 1'b1;
      if (grant) begin
        cmd  <= cmd_load;
        last <= cmd_load.owner;
      end
    end
  end

  assign cmd_active = (state != ST_IDLE);
  assign cmd_read   = cmd_active && !cmd.we;
  assign cmd_write  = cmd_active && cmd.we;

  assign mem_r_en_o   = cmd_read && !cmd.err;
  assign mem_sext_o   = cmd_read && cmd.sext;
  assign mem_acc_r_o  = cmd_read ? cmd.acc  : 2'b00;
  assign mem_addr_r_o = cmd_read ? cmd.addr : 32'h0;

  assign mem_wr_en_o  = cmd_write && !cmd.err && (state == ST_ISSUE);
  assign mem_acc_w_o  = cmd_write ? cmd.acc   : 2'b00;
  assign mem_addr_w_o = cmd_write ? cmd.addr  : 32'h0;
  assign mem_data_w_o = cmd_write ? cmd.wdata : 32'h0;

  assign if_resp = (state == ST_HOLD) && (cmd.owner == MEM_OWNER_FETCH);
  assign d_resp  = (state == ST_HOLD) && (cmd.owner == MEM_OWNER_DATA);

  assign if_rvalid_o = if_resp;
  assign if_err_o    = if_resp && cmd.err;
  assign if_rdata_o  = (if_resp && !cmd.err) ? mem_data_r_i : 32'h0;

  assign d_rvalid_o = d_resp && !cmd.we;
  assign d_wack_o   = d_resp && cmd.we;
  assign d_err_o    = d_resp && cmd.err;
  assign d_rdata_o  = (d_resp && !cmd.we && !cmd.err) ? mem_data_r_i : 32'h0;

  wr_ready_a: assert property (@(posedge clk_i) disable iff (!rstn_i) mem_wr_en_o |-> mem_wr_ready_i);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural mem_control stand-in, directed vectors and sequences,
// then randomized two-port traffic against a slot/round-robin reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam logic [31:0] MAP_ZERO = 32'h0;
  localparam int ROWS  = 512;
  localparam int BYTES = 4 * ROWS;

  logic        clk = 1'b0;
  logic        rstn, if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_sext, d_gnt, d_rvalid, d_wack, d_err;
  logic [1:0]  d_acc;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_sext, mem_r_en, mem_wr_en, mem_ready;
  logic [1:0]  mem_acc_r, mem_acc_w;
  logic [31:0] mem_addr_r, mem_data_r, mem_addr_w, mem_data_w;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.MAP_ZERO(MAP_ZERO), .ROWS(ROWS)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .d_req_i(d_req), .d_we_i(d_we), .d_acc_i(d_acc), .d_sext_i(d_sext),
    .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_gnt_o(d_gnt),
    .d_rvalid_o(d_rvalid), .d_wack_o(d_wack), .d_rdata_o(d_rdata), .d_err_o(d_err),
    .mem_sext_o(mem_sext), .mem_r_en_o(mem_r_en), .mem_acc_r_o(mem_acc_r),
    .mem_addr_r_o(mem_addr_r), .mem_data_r_i(mem_data_r),
    .mem_wr_en_o(mem_wr_en), .mem_acc_w_o(mem_acc_w), .mem_addr_w_o(mem_addr_w),
    .mem_data_w_o(mem_data_w), .mem_wr_ready_i(mem_ready)
  );

  always #5 clk = ~clk;

  // mem_control stand-in: byte array, aligns and rebases, registers read data one cycle later.
  logic [7:0] phys [BYTES];
  logic       preloaded = 1'b0;

  function automatic logic [10:0] boff(input logic [31:0] a, input logic [1:0] acc);
    logic [31:0] o;
    o = a - MAP_ZERO;
    if (acc == MEM_ACCESS_HALF) o[0] = 1'b0;
    else if (acc == MEM_ACCESS_WORD) o[1:0] = 2'b00;
    return o[10:0];
  endfunction

  function automatic logic [31:0] phys_read(input logic [31:0] a, input logic [1:0] acc, input logic sext);
    logic [10:0] b;
    logic [31:0] v;
    b = boff(a, acc);
    if (acc == MEM_ACCESS_BYTE) v = {{24{sext & phys[b][7]}}, phys[b]};
    else if (acc == MEM_ACCESS_HALF) v = {{16{sext & phys[b+11'd1][7]}}, phys[b+11'd1], phys[b]};
    else v = {phys[b+11'd3], phys[b+11'd2], phys[b+11'd1], phys[b]};
    return v;
  endfunction

  function automatic logic [31:0] pre_word(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < BYTES; i++) phys[i] <= 8'(pre_word(i / 4) >> (8 * (i % 4)));
      preloaded <= 1'b1;
    end
    if (!rstn) begin
      mem_data_r <= '0;
    end else begin
      if (mem_wr_en) begin
        phys[boff(mem_addr_w, mem_acc_w)] <= mem_data_w[7:0];
        if (mem_acc_w != MEM_ACCESS_BYTE) phys[boff(mem_addr_w, mem_acc_w) + 11'd1] <= mem_data_w[15:8];
        if (mem_acc_w == MEM_ACCESS_WORD) begin
          phys[boff(mem_addr_w, mem_acc_w) + 11'd2] <= mem_data_w[23:16];
          phys[boff(mem_addr_w, mem_acc_w) + 11'd3] <= mem_data_w[31:24];
        end
      end
      if (mem_r_en) mem_data_r <= phys_read(mem_addr_r, mem_acc_r, mem_sext);
    end
  end

  // Reference model: word array updated in grant order, values by shift/mask arithmetic.
  logic [31:0] ref_mem [ROWS];

  function automatic logic [8:0] ridx(input logic [31:0] a);
    logic [31:0] o;
    o = a - MAP_ZERO;
    return o[10:2];
  endfunction

  function automatic int ref_shift(input logic [31:0] a, input logic [1:0] acc);
    if (acc == MEM_ACCESS_BYTE) return 8 * int'(a[1:0]);
    if (acc == MEM_ACCESS_HALF) return 16 * int'(a[1]);
    return 0;
  endfunction

  function automatic logic [31:0] ref_mask(input logic [1:0] acc);
    if (acc == MEM_ACCESS_BYTE) return 32'hFF;
    if (acc == MEM_ACCESS_HALF) return 32'hFFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] acc, input logic sext);
    logic [31:0] v, m;
    m = ref_mask(acc);
    v = (ref_mem[ridx(a)] >> ref_shift(a, acc)) & m;
    if (sext && ((v & ((m >> 1) + 32'd1)) != 0)) v = v | ~m;
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [1:0] acc, input logic [31:0] d);
    logic [31:0] m;
    m = ref_mask(acc) << ref_shift(a, acc);
    ref_mem[ridx(a)] = (ref_mem[ridx(a)] & ~m) | ((d << ref_shift(a, acc)) & m);
  endtask

  function automatic logic ref_err(input logic [31:0] a, input logic [1:0] acc);
    longint addr;
    logic    bad;
    addr = longint'(a);
    bad  = (acc == MEM_ACCESS_HALF && a[0]) || (acc == MEM_ACCESS_WORD && a[1:0] != 2'b00);
    return bad || addr < longint'(MAP_ZERO) || addr >= longint'(MAP_ZERO) + 4 * ROWS;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  acc;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  // One data-port access from request to response, checking issue and response cycles.
  task automatic apply_stimulus(input vec_t v, input int idx);
    int waited;
    step();
    d_req = 1'b1; d_we = v.we; d_acc = v.acc; d_sext = v.sext; d_addr = v.addr; d_wdata = v.wdata;
    @(negedge clk);
    waited = 0;
    while (!d_gnt && waited < 8) begin
      step();
      @(negedge clk);
      waited++;
    end
    check_output($sformatf("vec%0d_gnt", idx), 32'(d_gnt), 32'd1);
    step();
    d_req = 1'b0;
    @(negedge clk);
    check_output($sformatf("vec%0d_wr_en", idx), 32'(mem_wr_en), 32'(v.we && !v.err));
    check_output($sformatf("vec%0d_r_en", idx), 32'(mem_r_en), 32'(!v.we && !v.err));
    step();
    @(negedge clk);
    check_output($sformatf("vec%0d_rvalid", idx), 32'(d_rvalid), 32'(!v.we));
    check_output($sformatf("vec%0d_wack", idx), 32'(d_wack), 32'(v.we));
    check_output($sformatf("vec%0d_err", idx), 32'(d_err), 32'(v.err));
    check_output($sformatf("vec%0d_rdata", idx), d_rdata, v.rdata);
    if (v.we && !v.err) ref_write(v.addr, v.acc, v.wdata);
  endtask

  task automatic fetch_access(input string name, input logic [31:0] a, input logic e, input logic [31:0] rd);
    step();
    if_req = 1'b1; if_addr = a;
    @(negedge clk);
    check_output({name, "_gnt"}, 32'(if_gnt), 32'd1);
    step();
    if_req = 1'b0;
    @(negedge clk);
    check_output({name, "_r_en"}, 32'(mem_r_en), 32'(!e));
    step();
    @(negedge clk);
    check_output({name, "_rvalid"}, 32'(if_rvalid), 32'd1);
    check_output({name, "_err"}, 32'(if_err), 32'(e));
    check_output({name, "_rdata"}, if_rdata, rd);
  endtask

  typedef struct {
    int          due;
    logic        owner;
    logic        we;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  vec_t  vecs [15];
  resp_t q [$];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int    cyc, last_g;
    logic  m_last, if_pend, d_pend, exp_if, exp_d, elig, has;
    resp_t r;

    for (int i = 0; i < ROWS; i++) ref_mem[i] = pre_word(i);
    vecs[0]  = '{1'b1, MEM_ACCESS_BYTE, 1'b0, 32'h005, 32'h0000_00A5, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, MEM_ACCESS_WORD, 1'b0, 32'h004, 32'h0, 1'b0, 32'hC0DE_A501};
    vecs[2]  = '{1'b0, MEM_ACCESS_BYTE, 1'b1, 32'h005, 32'h0, 1'b0, 32'hFFFF_FFA5};
    vecs[3]  = '{1'b0, MEM_ACCESS_BYTE, 1'b0, 32'h005, 32'h0, 1'b0, 32'h0000_00A5};
    vecs[4]  = '{1'b0, MEM_ACCESS_HALF, 1'b1, 32'h006, 32'h0, 1'b0, 32'hFFFF_C0DE};
    vecs[5]  = '{1'b0, MEM_ACCESS_HALF, 1'b0, 32'h006, 32'h0, 1'b0, 32'h0000_C0DE};
    vecs[6]  = '{1'b1, MEM_ACCESS_HALF, 1'b0, 32'h003, 32'h0000_BEEF, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, MEM_ACCESS_WORD, 1'b0, 32'h000, 32'h0, 1'b0, 32'hC0DE_0000};
    vecs[8]  = '{1'b0, MEM_ACCESS_WORD, 1'b0, 32'h002, 32'h0, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, MEM_ACCESS_WORD, 1'b0, 32'h800, 32'h0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, MEM_ACCESS_BYTE, 1'b0, 32'h7FF, 32'h0, 1'b0, 32'h0000_00C0};
    vecs[11] = '{1'b1, MEM_ACCESS_WORD, 1'b0, 32'h7FC, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[12] = '{1'b0, MEM_ACCESS_HALF, 1'b1, 32'h7FE, 32'h0, 1'b0, 32'hFFFF_DEAD};
    vecs[13] = '{1'b1, MEM_ACCESS_BYTE, 1'b0, 32'hFFFF_FFFF, 32'h11, 1'b1, 32'h0};
    vecs[14] = '{1'b0, MEM_ACCESS_HALF, 1'b1, 32'h001, 32'h0, 1'b1, 32'h0};

    rstn = 1'b0; mem_ready = 1'b0;
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_acc = MEM_ACCESS_WORD; d_sext = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;

    // Reset release: no grant until mem_control reports ready, then the fetch of 0x0.
    repeat (2) begin
      step();
      @(negedge clk);
      check_output("rst_gnt", 32'(if_gnt), 32'd0);
      check_output("rst_r_en", 32'(mem_r_en), 32'd0);
    end
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      @(negedge clk);
      check_output("gnt_before_ready", 32'(if_gnt), 32'd0);
    end
    step();
    mem_ready = 1'b1;
    @(negedge clk);
    check_output("gnt_ready_edge", 32'(if_gnt), 32'd0);
    step();
    @(negedge clk);
    check_output("gnt_after_ready", 32'(if_gnt), 32'd1);
    step();
    if_req = 1'b0;
    @(negedge clk);
    check_output("first_issue_r_en", 32'(mem_r_en), 32'd1);
    check_output("first_issue_addr", mem_addr_r, 32'h0);
    check_output("first_issue_acc", 32'(mem_acc_r), 32'(MEM_ACCESS_WORD));
    step();
    @(negedge clk);
    check_output("first_rvalid", 32'(if_rvalid), 32'd1);
    check_output("first_rdata", if_rdata, 32'hC0DE_0000);
    check_output("first_err", 32'(if_err), 32'd0);
    step();
    @(negedge clk);
    check_output("first_idle_rvalid", 32'(if_rvalid), 32'd0);

    // Simultaneous requests held for six cycles: data, fetch, data.
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 0) begin
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_acc = MEM_ACCESS_WORD; d_sext = 1'b0; d_addr = 32'hC;
      end
      if (c == 6) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      @(negedge clk);
      check_output($sformatf("rr_d_gnt_c%0d", c), 32'(d_gnt), 32'(c == 0 || c == 4));
      check_output($sformatf("rr_if_gnt_c%0d", c), 32'(if_gnt), 32'(c == 2));
      check_output($sformatf("rr_d_rvalid_c%0d", c), 32'(d_rvalid), 32'(c == 2 || c == 6));
      check_output($sformatf("rr_if_rvalid_c%0d", c), 32'(if_rvalid), 32'(c == 4));
      if (c == 2 || c == 6) check_output($sformatf("rr_d_rdata_c%0d", c), d_rdata, 32'hC0DE_0003);
      if (c == 4) check_output("rr_if_rdata", if_rdata, 32'hC0DE_0004);
    end

    for (int i = 0; i < 15; i++) apply_stimulus(vecs[i], i);

    fetch_access("fetch_oor", 32'h800, 1'b1, 32'h0);
    fetch_access("fetch_misal", 32'h2, 1'b1, 32'h0);

    // Back-to-back: write 0x8, then a fetch granted in the write's hold cycle.
    step();
    d_req = 1'b1; d_we = 1'b1; d_acc = MEM_ACCESS_WORD; d_addr = 32'h8; d_wdata = 32'h1234_5678;
    @(negedge clk);
    check_output("b2b_d_gnt", 32'(d_gnt), 32'd1);
    step();
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h8;
    @(negedge clk);
    check_output("b2b_wr_en", 32'(mem_wr_en), 32'd1);
    check_output("b2b_addr_w", mem_addr_w, 32'h8);
    check_output("b2b_data_w", mem_data_w, 32'h1234_5678);
    check_output("b2b_no_if_gnt", 32'(if_gnt), 32'd0);
    step();
    @(negedge clk);
    check_output("b2b_if_gnt", 32'(if_gnt), 32'd1);
    check_output("b2b_wack", 32'(d_wack), 32'd1);
    check_output("b2b_hold_wr_en", 32'(mem_wr_en), 32'd0);
    check_output("b2b_hold_addr_w", mem_addr_w, 32'h8);
    check_output("b2b_hold_r_en", 32'(mem_r_en), 32'd0);
    step();
    if_req = 1'b0;
    @(negedge clk);
    check_output("b2b_read_issue", 32'(mem_r_en), 32'd1);
    check_output("b2b_read_addr", mem_addr_r, 32'h8);
    step();
    @(negedge clk);
    check_output("b2b_rvalid", 32'(if_rvalid), 32'd1);
    check_output("b2b_rdata", if_rdata, 32'h1234_5678);
    ref_write(32'h8, MEM_ACCESS_WORD, 32'h1234_5678);

    // Reset during the issue cycle of a fetch: response dropped, regrant after ready returns.
    step();
    if_req = 1'b1; if_addr = 32'h4;
    @(negedge clk);
    check_output("rsti_gnt", 32'(if_gnt), 32'd1);
    step();
    if_req = 1'b0; rstn = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check_output("rsti_issue_r_en", 32'(mem_r_en), 32'd1);
    step();
    rstn = 1'b1; if_req = 1'b1;
    @(negedge clk);
    check_output("rsti_outputs_zero", 32'(|{if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_wack,
                 d_rdata, d_err, mem_sext, mem_r_en, mem_acc_r, mem_addr_r, mem_wr_en, mem_acc_w,
                 mem_addr_w, mem_data_w}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check_output("rsti_no_rvalid", 32'(if_rvalid), 32'd0);
      check_output("rsti_no_gnt", 32'(if_gnt), 32'd0);
    end
    step();
    mem_ready = 1'b1;
    @(negedge clk);
    check_output("rsti_gnt_ready_edge", 32'(if_gnt), 32'd0);
    step();
    @(negedge clk);
    check_output("rsti_regrant", 32'(if_gnt), 32'd1);
    step();
    if_req = 1'b0;
    step();
    @(negedge clk);
    check_output("rsti_rvalid", 32'(if_rvalid), 32'd1);
    check_output("rsti_rdata", if_rdata, 32'hC0DE_A501);

    // Randomized traffic: one grant per 2 cycles, round-robin ties, response at grant+2.
    m_last = MEM_OWNER_FETCH;
    last_g = -10;
    if_pend = 1'b0; d_pend = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      step();
      if (!if_pend) begin
        if (cyc < 390 && $urandom_range(0, 2) != 0) begin
          if_pend = 1'b1; if_req = 1'b1;
          if_addr = 32'($urandom_range(0, BYTES - 1));
          if ($urandom_range(0, 7) != 0) if_addr[1:0] = 2'b00;
          if ($urandom_range(0, 9) == 0) if_addr = $urandom | 32'h800;
        end else if_req = 1'b0;
      end
      if (!d_pend) begin
        if (cyc < 390 && $urandom_range(0, 2) != 0) begin
          d_pend = 1'b1; d_req = 1'b1;
          d_we = 1'($urandom_range(0, 1));
          d_acc = 2'($urandom_range(0, 2));
          d_sext = 1'($urandom_range(0, 1));
          d_wdata = $urandom;
          d_addr = 32'($urandom_range(0, BYTES - 1));
          if ($urandom_range(0, 5) != 0) d_addr = {d_addr[31:2], 2'b00};
          if ($urandom_range(0, 9) == 0) d_addr = $urandom | 32'h800;
        end else d_req = 1'b0;
      end
      @(negedge clk);
      elig   = (cyc - last_g) >= 2;
      exp_if = elig && if_req && (!d_req || m_last == MEM_OWNER_DATA);
      exp_d  = elig && d_req && (!if_req || m_last == MEM_OWNER_FETCH);
      check_output("rand_if_gnt", 32'(if_gnt), 32'(exp_if));
      check_output("rand_d_gnt", 32'(d_gnt), 32'(exp_d));
      if (exp_if) begin
        r.due = cyc + 2; r.owner = MEM_OWNER_FETCH; r.we = 1'b0;
        r.err = ref_err(if_addr, MEM_ACCESS_WORD);
        r.rdata = r.err ? 32'h0 : ref_read(if_addr, MEM_ACCESS_WORD, 1'b0);
        q.push_back(r);
        m_last = MEM_OWNER_FETCH; last_g = cyc; if_pend = 1'b0;
      end
      if (exp_d) begin
        r.due = cyc + 2; r.owner = MEM_OWNER_DATA; r.we = d_we;
        r.err = ref_err(d_addr, d_acc);
        r.rdata = (d_we || r.err) ? 32'h0 : ref_read(d_addr, d_acc, d_sext);
        if (d_we && !r.err) ref_write(d_addr, d_acc, d_wdata);
        q.push_back(r);
        m_last = MEM_OWNER_DATA; last_g = cyc; d_pend = 1'b0;
      end
      has = (q.size() > 0) && (q[0].due == cyc);
      r = '{0, 1'b0, 1'b0, 1'b0, 32'h0};
      if (has) r = q.pop_front();
      check_output("rand_if_rvalid", 32'(if_rvalid), 32'(has && r.owner == MEM_OWNER_FETCH));
      check_output("rand_if_err", 32'(if_err), 32'(has && r.owner == MEM_OWNER_FETCH && r.err));
      check_output("rand_if_rdata", if_rdata, (has && r.owner == MEM_OWNER_FETCH) ? r.rdata : 32'h0);
      check_output("rand_d_rvalid", 32'(d_rvalid), 32'(has && r.owner == MEM_OWNER_DATA && !r.we));
      check_output("rand_d_wack", 32'(d_wack), 32'(has && r.owner == MEM_OWNER_DATA && r.we));
      check_output("rand_d_err", 32'(d_err), 32'(has && r.owner == MEM_OWNER_DATA && r.err));
      check_output("rand_d_rdata", d_rdata, (has && r.owner == MEM_OWNER_DATA) ? r.rdata : 32'h0);
    end
    check_output("rand_queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester front end for `mem_control`. It shares the single memory between the instruction-fetch port (word reads only) and the load/store data port (byte, halfword or word reads and writes). It sequences each access into the 2-cycle slot that `mem_control` needs, and holds read-port and write-port attributes stable across that slot. It also enforces the alignment and range checks that `mem_control` does not perform, and returns a uniform-latency response with an error flag.

## Interface
Parameters:
- `MAP_ZERO`, 0: base byte address of the memory; must match the `mem_control` instance.
- `ROWS`, 512: number of 32b words; the valid range is [`MAP_ZERO`, `MAP_ZERO`+4*`ROWS`).

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rstn_i`  in  1  reset, synchronous, active-low.
- `if_req_i`  in  1  fetch request; held with `if_addr_i` until granted.
- `if_addr_i`  in  32  fetch byte address.
- `if_gnt_o`  out  1  fetch grant (combinational).
- `if_rvalid_o`  out  1  fetch response pulse.
- `if_rdata_o`  out  32  fetch data; valid only with `if_rvalid_o`.
- `if_err_o`  out  1  qualifies `if_rvalid_o`: misaligned or out-of-range access.
- `d_req_i`  in  1  data request; held with its attributes until granted.
- `d_we_i`  in  1  1 = write.
- `d_acc_i`  in  2  access size, `MEM_ACCESS_*`.
- `d_sext_i`  in  1  sign-extend a read.
- `d_addr_i`  in  32  byte address.
- `d_wdata_i`  in  32  write data, right-aligned.
- `d_gnt_o`  out  1  data grant (combinational).
- `d_rvalid_o`  out  1  read response pulse.
- `d_wack_o`  out  1  write completion pulse.
- `d_rdata_o`  out  32  read data.
- `d_err_o`  out  1  qualifies `d_rvalid_o` or `d_wack_o`.
- `mem_sext_o`, `mem_r_en_o`, `mem_acc_r_o[1:0]`, `mem_addr_r_o[31:0]`  out  read side of `mem_control`.
- `mem_data_r_i`  in  32  read data from `mem_control`.
- `mem_wr_en_o`, `mem_acc_w_o[1:0]`, `mem_addr_w_o[31:0]`, `mem_data_w_o[31:0]`  out  write side of `mem_control`.
- `mem_wr_ready_i`  in  1  `mem_control` ready.

## Operation
- State machine `ST_IDLE`, `ST_ISSUE`, `ST_HOLD`. A command register (owner, we, acc, sext, addr, wdata, err) is loaded on each grant and drives every `mem_*` output.
- Grants are allowed only in `ST_IDLE` or `ST_HOLD`, and only when the sticky flag `mem_up` is 1.
  - `mem_up` is cleared by reset and set on the first cycle in which `mem_wr_ready_i` is 1.
  - At most one grant per cycle. A grant moves the FSM to `ST_ISSUE`.
  - `ST_ISSUE` always moves to `ST_HOLD`.
  - `ST_HOLD` moves to `ST_ISSUE` if a grant occurs, otherwise to `ST_IDLE`.
- Arbitration is 2-way round-robin. A `last` bit records the most recent owner. On simultaneous requests, the port that was not last wins. Reset sets `last` to fetch, so data wins the first tie.
- Error check at grant:
  - halfword requires addr[0] = 0; word requires addr[1:0] = 0;
  - the address must be inside the valid range;
  - fetch is always a word access with `sext` = 0.
  - An erroring command still occupies a slot, but `mem_r_en_o` and `mem_wr_en_o` stay 0.
- Read command: in `ST_ISSUE` and `ST_HOLD`, `mem_r_en_o`=1 and the read attributes are driven from the command register. In `ST_HOLD`, the owner's `rvalid` is asserted and its rdata = `mem_data_r_i`, or 0 if err.
- Write command:
  - `mem_wr_en_o`=1 in `ST_ISSUE` only;
  - `mem_acc_w_o`, `mem_addr_w_o` and `mem_data_w_o` are held through `ST_HOLD`;
  - `mem_r_en_o` is 0 in both cycles;
  - `d_wack_o` is asserted in `ST_HOLD`.
- Outside an active command, all `mem_*` outputs are 0. Non-owner response outputs are always 0.
- `mem_wr_ready_i`=0 in a write `ST_ISSUE` is a protocol violation. Simulation-only assertion; no recovery logic.

## Timing
- Grant in cycle N. The memory access is issued in N+1, and the response pulse (`rvalid`/`wack`, plus err) is in N+2.
- Peak throughput is one access per 2 cycles. A grant in N+2 issues in N+3 (back-to-back).
- A requester sees `gnt` for exactly 1 cycle per request. It may change its inputs in N+1.
- Reset (sampled `rstn_i`=0):
  - next state `ST_IDLE`, `last`=fetch, `mem_up`=0, command register cleared;
  - all registered outputs are 0; `gnt` outputs are 0 while `mem_up`=0.
  - An in-flight command is dropped with no response.
- `mem_control` resets into its own reset state. `mem_up` guarantees no grant before `mem_wr_ready_i` first rises.
- Widths:
  - the range check is computed in 33 bits, so `MAP_ZERO`+4*`ROWS` near 2^32 does not wrap;
  - all addresses are passed through unmodified; `mem_control` aligns and rebases them.

## Structure
- `MEM_ACCESS_*` come from `const.v`.
- Add owner codes `MEM_OWNER_FETCH` and `MEM_OWNER_DATA`, plus the state encodings, to `const.v`.
- Sub-module `mem_arb_rr`: combinational 2-way round-robin picker. Inputs: two reqs, `last`, enable. Outputs: one-hot grant.
- Top-level `mem_arbiter` holds the FSM, command register and checks. It instantiates `mem_arb_rr` and, in the bench only, `mem_control`.

## Test plan
- Reset release: `mem_control` is in reset-state; a request at cycle 0 -> no `gnt` until `mem_wr_ready_i`=1; then `if_gnt_o`=1, and `if_rvalid_o` 2 cycles later with the preloaded word at 0x0.
- Simultaneous `if_req_i` and `d_req_i` held for 6 cycles -> grants alternate data, fetch, data at cycles N, N+2, N+4; each response arrives at grant+2.
- Store byte 0xA5 at 0x5, then load word 0x4 -> the read data has byte 1 = 0xA5 and the other bytes unchanged; the sign-extended byte load from 0x5 returns 0xFFFFFFA5.
- Store halfword to 0x3 -> `d_gnt_o`, `mem_wr_en_o` stays 0, `d_wack_o`=1 with `d_err_o`=1 at grant+2, and memory is unchanged. Fetch from `MAP_ZERO`+4*`ROWS` -> `if_err_o`=1, `if_rdata_o`=0.
- Back-to-back word write 0x12345678 to 0x8 followed immediately by a fetch from 0x8 -> the write issues in N+1, the read issues in N+3, and the fetch returns 0x12345678.
- Reset asserted in the `ST_ISSUE` cycle of a read -> no `rvalid` ever, all outputs are 0 the next cycle, and a new grant follows only after `mem_up` is set again.
